// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment scanner: drives one digit nibble and its active-low anode per slot, with blanking gaps.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL      = 27000,
    parameter int GAP        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_i,
    input  logic [4*NUM_DIGITS-1:0]       value_i,
    output logic [3:0]                    bcd_o,
    output logic [NUM_DIGITS-1:0]         an_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx_o,
    output logic                          pending_o
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int VW   = 4 * NUM_DIGITS;
    localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
    localparam int CW   = $clog2(MAXC + 1);

    // Reset loads GAP so the first blank spans exactly GAP cycles after release;
    // in-run reloads use N-1 because the loading edge already counts as one.
    localparam logic [CW-1:0] C_DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] C_GAP_LD   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [CW-1:0] C_GAP_RST  = CW'(GAP);
    localparam logic [IW-1:0] C_LAST     = IW'(NUM_DIGITS - 1);

    typedef enum logic {S_GAP, S_DRIVE} state_t;

    state_t              r_state;
    logic [CW-1:0]       r_cnt;
    logic [IW-1:0]       r_idx;
    logic [VW-1:0]       r_shadow;
    logic [VW-1:0]       r_disp;
    logic                r_pend;
    logic [NUM_DIGITS-1:0] r_an;
    logic [3:0]          r_bcd;

    state_t              w_state_nxt;
    logic [CW-1:0]       w_cnt_nxt;
    logic [IW-1:0]       w_idx_nxt;
    logic [VW-1:0]       w_shadow_nxt;
    logic [VW-1:0]       w_disp_nxt;
    logic                w_pend_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [3:0]          w_bcd_nxt;
    logic                w_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_GAP;
            r_cnt    <= C_GAP_RST;
            r_idx    <= '0;
            r_shadow <= '0;
            r_disp   <= '0;
            r_pend   <= 1'b0;
            r_an     <= '1;
            r_bcd    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_shadow <= w_shadow_nxt;
            r_disp   <= w_disp_nxt;
            r_pend   <= w_pend_nxt;
            r_an     <= w_an_nxt;
            r_bcd    <= w_bcd_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt - 1'b1;
        w_idx_nxt    = r_idx;
        w_shadow_nxt = r_shadow;
        w_disp_nxt   = r_disp;
        w_pend_nxt   = r_pend;
        w_an_nxt     = r_an;
        w_bcd_nxt    = r_bcd;
        w_entry      = 1'b0;

        case (r_state)
            S_GAP: begin
                if (r_cnt == '0) w_entry = 1'b1;
            end
            S_DRIVE: begin
                if (r_cnt == '0) begin
                    w_idx_nxt = (r_idx == C_LAST) ? '0 : r_idx + 1'b1;
                    if (GAP == 0) begin
                        w_entry = 1'b1;
                    end else begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = C_GAP_LD;
                        w_an_nxt    = '1;
                    end
                end
            end
            default: ;
        endcase

        // Display only changes on DRIVE entry; a same-cycle load bypasses the shadow.
        if (w_entry) begin
            w_state_nxt = S_DRIVE;
            w_cnt_nxt   = C_DWELL_LD;
            w_pend_nxt  = 1'b0;
            if (load_i)
                w_disp_nxt = value_i;
            else if (r_pend)
                w_disp_nxt = r_shadow;
            w_bcd_nxt = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];
            w_an_nxt  = ~(NUM_DIGITS'(1) << w_idx_nxt);
`ifdef SEG_SCAN_LZB_EN
            begin : lzb
                logic w_lz;
                w_lz = 1'b1;
                for (int k = 0; k < NUM_DIGITS; k++) begin
                    if (k >= int'(w_idx_nxt) && w_disp_nxt[4*k +: 4] != 4'h0)
                        w_lz = 1'b0;
                end
                if (w_idx_nxt != '0 && w_lz)
                    w_an_nxt = '1;
            end
`endif
        end else if (load_i) begin
            w_shadow_nxt = value_i;
            w_pend_nxt   = 1'b1;
        end
    end

    assign bcd_o       = r_bcd;
    assign an_o        = r_an;
    assign digit_idx_o = r_idx;
    assign pending_o   = r_pend;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux (4 digits, dwell 4, gap 2): a slot-timeline model
// pushes expected outputs per edge; they are popped and compared just after the edge.
module tb_seg_scan_mux;

    localparam int ND   = 4;
    localparam int DWL  = 4;
    localparam int GP   = 2;
    localparam int SLOT = DWL + GP;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_i;
    logic [15:0] value_i;
    logic [3:0]  bcd_o;
    logic [3:0]  an_o;
    logic [1:0]  digit_idx_o;
    logic        pending_o;

    always #5 clk = ~clk;

    seg_scan_mux #(.NUM_DIGITS(ND), .DWELL(DWL), .GAP(GP)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_i      (load_i),
        .value_i     (value_i),
        .bcd_o       (bcd_o),
        .an_o        (an_o),
        .digit_idx_o (digit_idx_o),
        .pending_o   (pending_o)
    );

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        logic [1:0] idx;
        logic       pend;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [15:0] m_disp, m_shadow;
    logic        m_pend;
    logic [3:0]  m_bcd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_disp   = '0;
        m_shadow = '0;
        m_pend   = 1'b0;
        m_bcd    = '0;
    endtask

    task automatic push_reset_exp();
        exp_t e;
        e.an = 4'hF; e.bcd = 4'h0; e.idx = 2'd0; e.pend = 1'b0;
        sb_q.push_back(e);
    endtask

    // Edge t after reset release: slot = t/SLOT, blank for the first GP cycles of each slot.
    task automatic model_edge(input int t, input logic ld, input logic [15:0] v);
        int   ph, idx;
        exp_t e;
        ph  = t % SLOT;
        idx = (t / SLOT) % ND;
        if (ph == GP) begin
            if (ld) m_disp = v;
            else if (m_pend) m_disp = m_shadow;
            m_pend = 1'b0;
        end else if (ld) begin
            m_shadow = v;
            m_pend   = 1'b1;
        end
        e.idx  = 2'(idx);
        e.pend = m_pend;
        if (ph >= GP) begin
            m_bcd = m_disp[4*idx +: 4];
            e.an  = ~(4'b0001 << idx);
`ifdef SEG_SCAN_LZB_EN
            if (idx > 0 && (m_disp >> (4*idx)) == 16'h0) e.an = 4'hF;
`endif
        end else begin
            e.an = 4'hF;
        end
        e.bcd = m_bcd;
        sb_q.push_back(e);
    endtask

    task automatic compare_out(input string where);
        exp_t e;
        check({where, ".sb_depth"}, sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({where, ".an"},   an_o,        e.an);
            check({where, ".bcd"},  bcd_o,       e.bcd);
            check({where, ".idx"},  digit_idx_o, e.idx);
            check({where, ".pend"}, pending_o,   e.pend);
        end
    endtask

    task automatic sched(input int t, output logic ld, output logic [15:0] v);
        ld = 1'b1;
        case (t)
            3:       v = 16'h1234;
            30:      v = 16'hAAAA;
            31:      v = 16'h5555;
            56:      v = 16'h00F0;
            87:      v = 16'h0050;
            129:     v = 16'h0777;
            default: begin ld = 1'b0; v = 16'($urandom); end
        endcase
    endtask

    task automatic run(input int n, input bit use_sched);
        for (int t = 0; t < n; t++) begin
            logic        ld;
            logic [15:0] v;
            if (use_sched) sched(t, ld, v);
            else begin ld = 1'b0; v = 16'($urandom); end
            load_i  = ld;
            value_i = v;
            @(posedge clk);
            model_edge(t, ld, v);
            #1 compare_out($sformatf("t%0d", t));
            @(negedge clk);
        end
        load_i = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        load_i  = 1'b0;
        value_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        push_reset_exp();
        compare_out("rst_init");

        rst = 1'b0;
        run(130, 1'b1);

        // Mid-DRIVE of digit 1 with a pending load: reset must clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        push_reset_exp();
        compare_out("rst_async");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(30, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
